// File: rtl/mm_result_drain_if.sv
// Result-drain port bundle: per-column write lanes from the array plus the row-wide output stream.
// The master side is the upstream array and downstream sink; the slave side is mm_result_drain.
interface mm_result_drain_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ROW_NUM    = 32,
    parameter int COL_NUM    = 32
);
    localparam int RES_W          = 4 * DATA_WIDTH;
    localparam int ROW_ADDR_WIDTH = $clog2(ROW_NUM);

    logic [RES_W*COL_NUM-1:0]          row_data_in;
    logic [ROW_ADDR_WIDTH*COL_NUM-1:0] row_wraddr;
    logic [COL_NUM-1:0]                row_wr_en;
    logic                              acc_rdy;
    logic                              overflow;
    logic                              out_val;
    logic                              out_rdy;
    logic [RES_W*COL_NUM-1:0]          out_data;
    logic [ROW_ADDR_WIDTH-1:0]         out_row_idx;
    logic                              out_last;

    modport master (
        output row_data_in, row_wraddr, row_wr_en, out_rdy,
        input  acc_rdy, overflow, out_val, out_data, out_row_idx, out_last
    );

    modport slave (
        input  row_data_in, row_wraddr, row_wr_en, out_rdy,
        output acc_rdy, overflow, out_val, out_data, out_row_idx, out_last
    );
endinterface

// File: rtl/mm_result_drain.sv
// Ping-pong result buffer: columns fill a bank independently, then whole rows stream out
// through a valid/ready port while the other bank fills.
//
// state   | meaning
// S_IDLE  | no full bank pending at rd_sel, out_val low
// S_DRAIN | out_data holds a row of bank rd_sel, waiting for out_rdy
module mm_result_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int ROW_NUM    = 32,
    parameter int COL_NUM    = 32
) (
    input  logic             clk,
    input  logic             reset,
    mm_result_drain_if.slave bus
);
    localparam int RES_W          = 4 * DATA_WIDTH;
    localparam int ROW_ADDR_WIDTH = $clog2(ROW_NUM);
    localparam int CNT_W          = ROW_ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0]          CNT_FULL = CNT_W'(ROW_NUM);
    localparam logic [ROW_ADDR_WIDTH-1:0] ROW_LAST = ROW_ADDR_WIDTH'(ROW_NUM - 1);

    typedef enum logic {S_IDLE, S_DRAIN} state_t;

    logic [RES_W-1:0]          r_mem [2][ROW_NUM][COL_NUM];
    logic [CNT_W-1:0]          r_wr_cnt [COL_NUM];
    logic [1:0]                r_full;
    logic                      r_wr_sel;
    logic                      r_rd_sel;
    logic                      r_overflow;
    state_t                    r_state;
    logic                      r_out_val;
    logic                      r_out_last;
    logic [RES_W*COL_NUM-1:0]  r_out_data;
    logic [ROW_ADDR_WIDTH-1:0] r_out_row_idx;

    logic [ROW_ADDR_WIDTH-1:0] w_wr_addr [COL_NUM];
    logic [RES_W-1:0]          w_wr_data [COL_NUM];
    logic [CNT_W-1:0]          w_cnt_nxt [COL_NUM];
    logic [COL_NUM-1:0]        w_wr_acc;
    logic                      w_acc_rdy;
    logic                      w_fill_done;
    logic                      w_other_full;
    logic [1:0]                w_full_nxt;
    state_t                    w_state_nxt;
    logic                      w_load;
    logic                      w_ld_bank;
    logic [ROW_ADDR_WIDTH-1:0] w_ld_row;
    logic                      w_val_nxt;
    logic                      w_clr_full;
    logic                      w_rd_sel_nxt;
    logic [RES_W*COL_NUM-1:0]  w_rd_row;

    genvar g;
    generate
        for (g = 0; g < COL_NUM; g++) begin : g_lane
            assign w_wr_addr[g] = bus.row_wraddr[g*ROW_ADDR_WIDTH +: ROW_ADDR_WIDTH];
            assign w_wr_data[g] = bus.row_data_in[g*RES_W +: RES_W];
        end
    endgenerate

    assign w_acc_rdy = ~r_full[r_wr_sel];
    assign w_wr_acc  = bus.row_wr_en & {COL_NUM{w_acc_rdy}};

    // Counters saturate so a column that over-strobes cannot wrap past the tile size.
    always_comb begin
        w_fill_done = 1'b1;
        for (int c = 0; c < COL_NUM; c++) begin
            w_cnt_nxt[c] = r_wr_cnt[c];
            if (w_wr_acc[c] && (r_wr_cnt[c] != CNT_FULL)) begin
                w_cnt_nxt[c] = r_wr_cnt[c] + CNT_W'(1);
            end
            if (w_cnt_nxt[c] != CNT_FULL) begin
                w_fill_done = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < COL_NUM; c++) begin
            if (w_wr_acc[c]) begin
                r_mem[r_wr_sel][w_wr_addr[c]][c] <= w_wr_data[c];
            end
        end
    end

    // Fill and drain always target different banks, so set and clear never collide.
    always_comb begin
        w_full_nxt = r_full;
        if (w_fill_done) begin
            w_full_nxt[r_wr_sel] = 1'b1;
        end
        if (w_clr_full) begin
            w_full_nxt[r_rd_sel] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < COL_NUM; c++) begin
                r_wr_cnt[c] <= '0;
            end
            r_full     <= '0;
            r_wr_sel   <= 1'b0;
            r_rd_sel   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            for (int c = 0; c < COL_NUM; c++) begin
                r_wr_cnt[c] <= w_fill_done ? '0 : w_cnt_nxt[c];
            end
            if (w_fill_done) begin
                r_wr_sel <= ~r_wr_sel;
            end
            if ((|bus.row_wr_en) && !w_acc_rdy) begin
                r_overflow <= 1'b1;
            end
            r_full   <= w_full_nxt;
            r_rd_sel <= w_rd_sel_nxt;
        end
    end

    // The other bank counts as full if its last strobe lands on this very edge.
    assign w_other_full = r_full[~r_rd_sel] | (w_fill_done & (r_wr_sel != r_rd_sel));

    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_ld_bank    = r_rd_sel;
        w_ld_row     = '0;
        w_val_nxt    = r_out_val;
        w_clr_full   = 1'b0;
        w_rd_sel_nxt = r_rd_sel;
        case (r_state)
            S_IDLE: begin
                if (r_full[r_rd_sel]) begin
                    w_load      = 1'b1;
                    w_val_nxt   = 1'b1;
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_out_val && bus.out_rdy) begin
                    if (r_out_last) begin
                        w_clr_full   = 1'b1;
                        w_rd_sel_nxt = ~r_rd_sel;
                        if (w_other_full) begin
                            w_load    = 1'b1;
                            w_ld_bank = ~r_rd_sel;
                        end else begin
                            w_val_nxt   = 1'b0;
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_load   = 1'b1;
                        w_ld_row = r_out_row_idx + ROW_ADDR_WIDTH'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_val_nxt   = 1'b0;
            end
        endcase
    end

    // A lane written on the load edge is forwarded so a back-to-back tile sees its final write.
    always_comb begin
        w_rd_row = '0;
        for (int c = 0; c < COL_NUM; c++) begin
            w_rd_row[c*RES_W +: RES_W] = r_mem[w_ld_bank][w_ld_row][c];
            if (w_wr_acc[c] && (r_wr_sel == w_ld_bank) && (w_wr_addr[c] == w_ld_row)) begin
                w_rd_row[c*RES_W +: RES_W] = w_wr_data[c];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_out_val     <= 1'b0;
            r_out_data    <= '0;
            r_out_row_idx <= '0;
            r_out_last    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_out_val <= w_val_nxt;
            if (w_load) begin
                r_out_data    <= w_rd_row;
                r_out_row_idx <= w_ld_row;
                r_out_last    <= (w_ld_row == ROW_LAST);
            end
        end
    end

    assign bus.acc_rdy     = w_acc_rdy;
    assign bus.overflow    = r_overflow;
    assign bus.out_val     = r_out_val;
    assign bus.out_data    = r_out_data;
    assign bus.out_row_idx = r_out_row_idx;
    assign bus.out_last    = r_out_last;
endmodule

// File: tb/tb_mm_result_drain.sv
// Scoreboard bench for mm_result_drain with 4 rows x 2 columns of 32-bit results.
module tb_mm_result_drain;
    localparam int DW = 8;
    localparam int RN = 4;
    localparam int CN = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mm_result_drain_if #(.DATA_WIDTH(DW), .ROW_NUM(RN), .COL_NUM(CN)) bus();

    mm_result_drain #(.DATA_WIDTH(DW), .ROW_NUM(RN), .COL_NUM(CN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] data;
        logic [1:0]  idx;
        logic        last;
    } row_t;

    row_t        sb[$];
    row_t        exp_r;
    int          xfer_cyc[$];
    int          cyc   = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic        stall_q = 1'b0;
    logic [63:0] data_q;
    logic [1:0]  idx_q;
    logic        last_q;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] tval(input int base, input int r, input int c);
        return 32'(base + 16 * r + c);
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("hold_val", bus.out_val, 1'b1);
                check("hold_data", bus.out_data, data_q);
                check("hold_idx", bus.out_row_idx, idx_q);
                check("hold_last", bus.out_last, last_q);
            end
            if (bus.out_val && bus.out_rdy) begin
                xfer_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    check("unexpected_row", bus.out_val, 1'b0);
                end else begin
                    exp_r = sb.pop_front();
                    check("row_data", bus.out_data, exp_r.data);
                    check("row_idx", bus.out_row_idx, exp_r.idx);
                    check("row_last", bus.out_last, exp_r.last);
                end
            end
            stall_q = bus.out_val && !bus.out_rdy;
            data_q  = bus.out_data;
            idx_q   = bus.out_row_idx;
            last_q  = bus.out_last;
        end
    end

    task automatic drive(input logic [1:0] en, input logic [1:0] a0, input logic [1:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
        bus.row_wr_en   = en;
        bus.row_wraddr  = {a1, a0};
        bus.row_data_in = {d1, d0};
        @(posedge clk);
        #1;
        bus.row_wr_en = '0;
    endtask

    task automatic push_tile(input int base);
        row_t e;
        for (int r = 0; r < RN; r++) begin
            e.data = {tval(base, r, 1), tval(base, r, 0)};
            e.idx  = 2'(r);
            e.last = (r == RN - 1);
            sb.push_back(e);
        end
    endtask

    task automatic fill_tile(input int base);
        for (int r = 0; r < RN; r++) begin
            drive(2'b11, 2'(r), 2'(r), tval(base, r, 0), tval(base, r, 1));
        end
        push_tile(base);
    endtask

    task automatic do_reset(input string pfx);
        reset = 1'b0;
        #1;
        check({pfx, "_val"}, bus.out_val, 1'b0);
        check({pfx, "_data"}, bus.out_data, 64'h0);
        check({pfx, "_idx"}, bus.out_row_idx, 2'd0);
        check({pfx, "_last"}, bus.out_last, 1'b0);
        check({pfx, "_ovf"}, bus.overflow, 1'b0);
        check({pfx, "_accrdy"}, bus.acc_rdy, 1'b1);
        sb.delete();
        xfer_cyc.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_left"}, 64'(sb.size()), 64'd0);
        check({tag, "_idle"}, bus.out_val, 1'b0);
    endtask

    task automatic wait_val(input string tag);
        for (int i = 0; i < 10; i++) begin
            if (bus.out_val) break;
            @(posedge clk);
            #1;
        end
        check(tag, bus.out_val, 1'b1);
    endtask

    initial begin
        logic [11:0] pat;
        bus.row_wr_en   = '0;
        bus.row_wraddr  = '0;
        bus.row_data_in = '0;
        bus.out_rdy     = 1'b0;
        #2;
        do_reset("rst0");

        // single tile, ready held high
        bus.out_rdy = 1'b1;
        fill_tile(0);
        repeat (2) @(posedge clk);
        #1;
        check("t1_lat", bus.out_val, 1'b1);
        wait_drain("t1");
        check("t1_nxfer", 64'(xfer_cyc.size()), 64'd4);
        if (xfer_cyc.size() == 4) check("t1_tput", 64'(xfer_cyc[3] - xfer_cyc[0]), 64'd3);
        check("t1_accrdy", bus.acc_rdy, 1'b1);

        // columns filled at different times, column 1 in reverse address order
        @(posedge clk);
        #2;
        do_reset("t2_rst");
        bus.out_rdy = 1'b1;
        for (int r = 0; r < RN; r++) drive(2'b01, 2'(r), 2'd0, tval(32'h200, r, 0), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < RN; k++) begin
            if (k == RN - 1) begin
                check("t2_early_val", bus.out_val, 1'b0);
                check("t2_early_rdy", bus.acc_rdy, 1'b1);
            end
            drive(2'b10, 2'd0, 2'(RN - 1 - k), 32'h0, tval(32'h200, RN - 1 - k, 1));
        end
        push_tile(32'h200);
        wait_drain("t2");

        // both banks full with ready low, overflow on extra strobe
        @(posedge clk);
        #2;
        do_reset("t3_rst");
        bus.out_rdy = 1'b0;
        fill_tile(32'h100);
        fill_tile(32'h180);
        check("t3_accrdy_lo", bus.acc_rdy, 1'b0);
        check("t3_ovf_clr", bus.overflow, 1'b0);
        drive(2'b11, 2'd1, 2'd2, 32'hdead, 32'hbeef);
        check("t3_ovf_set", bus.overflow, 1'b1);
        check("t3_accrdy_still", bus.acc_rdy, 1'b0);
        bus.out_rdy = 1'b1;
        wait_drain("t3");
        check("t3_ovf_sticky", bus.overflow, 1'b1);
        check("t3_accrdy_hi", bus.acc_rdy, 1'b1);

        // ready toggling during drain
        @(posedge clk);
        #2;
        do_reset("t4_rst");
        bus.out_rdy = 1'b0;
        fill_tile(32'h300);
        wait_val("t4_val");
        pat = 12'b1111_1101_1001;
        for (int i = 0; i < 12; i++) begin
            bus.out_rdy = pat[i];
            @(posedge clk);
            #1;
        end
        bus.out_rdy = 1'b1;
        wait_drain("t4");

        // tile B completes on the edge that transfers tile A's last row
        @(posedge clk);
        #2;
        do_reset("t5_rst");
        bus.out_rdy = 1'b0;
        fill_tile(32'h600);
        for (int r = 0; r < RN; r++) drive(2'b01, 2'(r), 2'd0, tval(32'h700, r, 0), 32'h0);
        for (int r = RN - 1; r > 0; r--) drive(2'b10, 2'd0, 2'(r), 32'h0, tval(32'h700, r, 1));
        xfer_cyc.delete();
        bus.out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t5_sync_last", bus.out_last, 1'b1);
        drive(2'b10, 2'd0, 2'd0, 32'h0, tval(32'h700, 0, 1));
        push_tile(32'h700);
        wait_drain("t5");
        check("t5_nxfer", 64'(xfer_cyc.size()), 64'd8);
        if (xfer_cyc.size() == 8) check("t5_nogap", 64'(xfer_cyc[7] - xfer_cyc[0]), 64'd7);
        check("t5_accrdy", bus.acc_rdy, 1'b1);

        // reset in the middle of a drain
        @(posedge clk);
        #2;
        do_reset("t6_rst0");
        bus.out_rdy = 1'b0;
        fill_tile(32'h400);
        wait_val("t6_val");
        bus.out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.out_rdy = 1'b0;
        check("t6_row2", bus.out_row_idx, 2'd2);
        #2;
        do_reset("t6_mid");
        bus.out_rdy = 1'b1;
        fill_tile(32'h500);
        wait_drain("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
